// File: rtl/md_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : md_sched_if
//  Description : EX-stage request / HI-LO result bundle between the pipeline
//                decode and the multiply/divide scheduler.
//  Revision    : 1.0  initial release
// ============================================================================
interface md_sched_if;
    logic        ex_valid;
    logic [3:0]  ex_mdop;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic        id_is_md;
    logic        start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_rdata;
    logic        md_stall;

    // Pipeline side: drives the request, observes status and results.
    modport master (
        output ex_valid, ex_mdop, ex_a, ex_b, id_is_md,
        input  start, busy, hi, lo, md_rdata, md_stall
    );

    // Scheduler side.
    modport slave (
        input  ex_valid, ex_mdop, ex_a, ex_b, id_is_md,
        output start, busy, hi, lo, md_rdata, md_stall
    );
endinterface
`default_nettype wire

// File: rtl/md_sched.sv
`default_nettype none
// ============================================================================
//  Module      : md_sched
//  Description : Multi-cycle multiply/divide scheduler owning HI/LO. Results
//                are computed at issue, held in pending registers, and
//                committed to HI/LO when the fixed latency expires.
//  Revision    : 1.0  initial release
// ============================================================================
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    md_sched_if.slave   bus
);
    localparam int c_MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CW      = $clog2(c_MAX_CYC + 1);

    localparam logic [3:0] c_OP_MULT  = 4'd1;
    localparam logic [3:0] c_OP_MULTU = 4'd2;
    localparam logic [3:0] c_OP_DIV   = 4'd3;
    localparam logic [3:0] c_OP_DIVU  = 4'd4;
    localparam logic [3:0] c_OP_MFHI  = 4'd5;
    localparam logic [3:0] c_OP_MFLO  = 4'd6;
    localparam logic [3:0] c_OP_MTHI  = 4'd7;
    localparam logic [3:0] c_OP_MTLO  = 4'd8;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [c_CW-1:0]   cnt_q, cnt_d;
    logic [31:0]       pend_hi_q, pend_hi_d;
    logic [31:0]       pend_lo_q, pend_lo_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;

    logic              w_busy;
    logic              w_is_mul;
    logic              w_is_div;
    logic              w_start;
    logic [63:0]       w_opa64, w_opb64, w_prod;
    logic              w_neg_a, w_neg_b;
    logic [31:0]       w_mag_a, w_mag_b, w_uq, w_ur, w_q, w_r;
    logic [63:0]       w_res;

    assign w_busy   = (state_q == S_RUN);
    assign w_is_mul = (bus.ex_mdop == c_OP_MULT) || (bus.ex_mdop == c_OP_MULTU);
    assign w_is_div = (bus.ex_mdop == c_OP_DIV)  || (bus.ex_mdop == c_OP_DIVU);
    assign w_start  = bus.ex_valid & ~w_busy & (w_is_mul | w_is_div);

    // One 64x64 multiplier serves both flavours; sign-extension selects signed.
    assign w_opa64 = (bus.ex_mdop == c_OP_MULT) ? {{32{bus.ex_a[31]}}, bus.ex_a} : {32'd0, bus.ex_a};
    assign w_opb64 = (bus.ex_mdop == c_OP_MULT) ? {{32{bus.ex_b[31]}}, bus.ex_b} : {32'd0, bus.ex_b};
    assign w_prod  = w_opa64 * w_opb64;

    // Signed divide via magnitudes; quotient truncates toward zero and the
    // remainder follows the dividend. 0x80000000 / -1 wraps to 0x80000000.
    assign w_neg_a = (bus.ex_mdop == c_OP_DIV) & bus.ex_a[31];
    assign w_neg_b = (bus.ex_mdop == c_OP_DIV) & bus.ex_b[31];
    assign w_mag_a = w_neg_a ? (32'd0 - bus.ex_a) : bus.ex_a;
    assign w_mag_b = w_neg_b ? (32'd0 - bus.ex_b) : bus.ex_b;
    assign w_uq    = (w_mag_b != 32'd0) ? (w_mag_a / w_mag_b) : 32'd0;
    assign w_ur    = (w_mag_b != 32'd0) ? (w_mag_a % w_mag_b) : 32'd0;
    assign w_q     = (w_neg_a ^ w_neg_b) ? (32'd0 - w_uq) : w_uq;
    assign w_r     = w_neg_a ? (32'd0 - w_ur) : w_ur;

    // Divide by zero re-commits the current HI/LO, which cannot change while busy.
    assign w_res = w_is_mul                 ? w_prod :
                   (bus.ex_b == 32'd0)      ? {hi_q, lo_q} :
                                              {w_r, w_q};

    // State, counter, pending result and HI/LO registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // Next-state: issue in IDLE, count down in RUN, commit on the last cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            S_IDLE: begin
                if (w_start) begin
                    state_d   = S_RUN;
                    cnt_d     = w_is_mul ? c_CW'(MULT_CYCLES) : c_CW'(DIV_CYCLES);
                    pend_hi_d = w_res[63:32];
                    pend_lo_d = w_res[31:0];
                end else if (bus.ex_valid && (bus.ex_mdop == c_OP_MTHI)) begin
                    hi_d = bus.ex_a;
                end else if (bus.ex_valid && (bus.ex_mdop == c_OP_MTLO)) begin
                    lo_d = bus.ex_a;
                end
            end
            S_RUN: begin
                if (cnt_q == c_CW'(1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                end else begin
                    cnt_d = cnt_q - c_CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.start    = w_start;
    assign bus.busy     = w_busy;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.md_rdata = (bus.ex_mdop == c_OP_MFHI) ? hi_q :
                          (bus.ex_mdop == c_OP_MFLO) ? lo_q : 32'd0;
    assign bus.md_stall = bus.id_is_md & (w_busy | w_start);
endmodule
`default_nettype wire

// File: tb/tb_md_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_md_sched
//  Description : Self-checking bench for md_sched: operation table with a
//                result scoreboard, plus hazard and reset-abort sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_md_sched;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    md_sched_if u_if ();

    md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_cyc;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        u_if.ex_valid = v;
        u_if.ex_mdop  = op;
        u_if.ex_a     = a;
        u_if.ex_b     = b;
    endtask

    task automatic preload(input logic [31:0] h, input logic [31:0] l);
        drive(1'b1, 4'd7, h, 32'd0);
        tick();
        drive(1'b1, 4'd8, l, 32'd0);
        tick();
        drive(1'b0, 4'd0, 32'd0, 32'd0);
    endtask

    initial begin
        int          cyc;
        logic        held;
        logic        stall_ok;
        sb_t         e;

        n_cmp = 0;
        n_err = 0;
        //            op     a             b             pre_hi        pre_lo        exp_hi        exp_lo        cyc
        vecs[0] = '{4'd1, 32'hFFFFFFFF, 32'h00000002, 32'h00000123, 32'h00000456, 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
        vecs[1] = '{4'd2, 32'hFFFFFFFF, 32'h00000002, 32'h00000000, 32'h00000000, 32'h00000001, 32'hFFFFFFFE, 5};
        vecs[2] = '{4'd3, 32'hFFFFFFF9, 32'h00000002, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3] = '{4'd4, 32'h00000007, 32'h00000000, 32'h00000011, 32'h00000022, 32'h00000011, 32'h00000022, 10};
        vecs[4] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000009, 32'h00000009, 32'h00000000, 32'h80000000, 10};
        vecs[5] = '{4'd4, 32'h00000064, 32'h00000007, 32'h00000000, 32'h00000000, 32'h00000002, 32'h0000000E, 10};
        vecs[6] = '{4'd1, 32'h00000007, 32'hFFFFFFFD, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFEB, 5};
        vecs[7] = '{4'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000000, 32'h00000000, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[8] = '{4'd2, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000000, 32'h00000001, 32'h00000000, 5};
        vecs[9] = '{4'd3, 32'h00000005, 32'h00000000, 32'h000000AA, 32'h000000BB, 32'h000000AA, 32'h000000BB, 10};

        reset = 1'b0;
        u_if.id_is_md = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        tick();
        tick();
        chk("reset_busy", {31'd0, u_if.busy}, 32'd0);
        chk("reset_hi", u_if.hi, 32'd0);
        chk("reset_lo", u_if.lo, 32'd0);
        reset = 1'b1;
        tick();
        chk("idle_stall", {31'd0, u_if.md_stall}, 32'd0);

        // Operation table with scoreboard.
        for (int i = 0; i < 10; i++) begin
            preload(vecs[i].pre_hi, vecs[i].pre_lo);
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
            #1;
            chk($sformatf("v%0d_start", i), {31'd0, u_if.start}, 32'd1);
            sb_q.push_back('{vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_cyc});
            tick();
            drive(1'b0, 4'd0, 32'd0, 32'd0);
            cyc  = 0;
            held = 1'b1;
            while (u_if.busy && cyc < 100) begin
                if (u_if.hi !== vecs[i].pre_hi || u_if.lo !== vecs[i].pre_lo) held = 1'b0;
                cyc++;
                tick();
            end
            e = sb_q.pop_front();
            chk($sformatf("v%0d_held", i), {31'd0, held}, 32'd1);
            chk($sformatf("v%0d_cycles", i), cyc, e.cyc);
            chk($sformatf("v%0d_hi", i), u_if.hi, e.hi);
            chk($sformatf("v%0d_lo", i), u_if.lo, e.lo);
            drive(1'b1, 4'd5, 32'd0, 32'd0);
            #1;
            chk($sformatf("v%0d_mfhi", i), u_if.md_rdata, e.hi);
            drive(1'b0, 4'd0, 32'd0, 32'd0);
        end

        // Hazard: stall through start and busy, ops ignored while busy.
        preload(32'd0, 32'd0);
        u_if.id_is_md = 1'b1;
        drive(1'b1, 4'd1, 32'd3, 32'd4);
        #1;
        chk("hz_stall_start", {31'd0, u_if.md_stall}, 32'd1);
        tick();
        cyc      = 0;
        stall_ok = 1'b1;
        while (u_if.busy && cyc < 100) begin
            if (!u_if.md_stall) stall_ok = 1'b0;
            if (cyc == 1) begin
                drive(1'b1, 4'd8, 32'd5, 32'd0);
            end else if (cyc == 2) begin
                drive(1'b1, 4'd3, 32'd9, 32'd3);
                #1;
                chk("hz_no_start_busy", {31'd0, u_if.start}, 32'd0);
            end else begin
                drive(1'b0, 4'd0, 32'd0, 32'd0);
            end
            cyc++;
            tick();
        end
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        #1;
        chk("hz_stall_busy", {31'd0, stall_ok}, 32'd1);
        chk("hz_cycles", cyc, 5);
        chk("hz_stall_after", {31'd0, u_if.md_stall}, 32'd0);
        chk("hz_hi", u_if.hi, 32'd0);
        chk("hz_lo", u_if.lo, 32'd12);
        drive(1'b1, 4'd6, 32'd0, 32'd0);
        #1;
        chk("hz_mflo", u_if.md_rdata, 32'd12);
        drive(1'b1, 4'd15, 32'd0, 32'd0);
        #1;
        chk("hz_rdata_none", u_if.md_rdata, 32'd0);
        u_if.id_is_md = 1'b0;
        drive(1'b0, 4'd7, 32'hDEAD, 32'd0);
        tick();
        chk("novalid_mthi", u_if.hi, 32'd0);
        drive(1'b0, 4'd0, 32'd0, 32'd0);

        // Reset in busy cycle 3 of a div discards the result.
        preload(32'h33, 32'h44);
        drive(1'b1, 4'd4, 32'd100, 32'd7);
        tick();
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        tick();
        tick();
        chk("rst_busy_before", {31'd0, u_if.busy}, 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("rst_busy", {31'd0, u_if.busy}, 32'd0);
        chk("rst_hi", u_if.hi, 32'd0);
        chk("rst_lo", u_if.lo, 32'd0);
        repeat (12) tick();
        chk("rst_late_hi", u_if.hi, 32'd0);
        chk("rst_late_lo", u_if.lo, 32'd0);
        chk("rst_late_busy", {31'd0, u_if.busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/md_sched.md
Name: md_sched

Overview:
- Multi-cycle multiply/divide scheduler for the pipelined MIPS core.
- Sits in EX beside the ALU. It accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo from the EX-stage decode, runs products and quotients over fixed latencies, and owns the HI/LO registers.
- Raises a stall request to the hazard logic when an ID-stage md-class instruction must wait.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be >= 1).
- DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1).

Ports:
- clk  input  1  core clock.
- reset  input  1  synchronous, active-low reset.
- ex_valid  input  1  EX holds a real (non-bubble) instruction.
- ex_mdop  input  4  EX md operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9-15 treated as none.
- ex_a  input  32  rs operand (forwarded).
- ex_b  input  32  rt operand (forwarded).
- id_is_md  input  1  ID instruction is any md-class op (opcodes 1-8).
- start  output  1  combinational: ex_valid & busy==0 & ex_mdop in 1..4.
- busy  output  1  registered; operation in flight.
- hi  output  32  HI register.
- lo  output  32  LO register.
- md_rdata  output  32  combinational: hi when ex_mdop==5, lo when ex_mdop==6, else 0.
- md_stall  output  1  combinational: id_is_md & (busy | start).

Behaviour:
- Reset (reset==0 at a rising edge):
  - busy=0, hi=0, lo=0, counter=0, pending results=0.
  - Overrides everything else, including an in-flight operation; its result is discarded.
- States: IDLE (busy=0) and RUN (busy=1).
- IDLE -> RUN on start:
  - On that edge, latch the 64-bit result into pending registers; HI/LO are not yet written.
  - Load counter with MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4).
- RUN: counter decrements each cycle.
  - When counter==1, at that edge: hi<=pending_hi, lo<=pending_lo, busy<=0, return to IDLE.
  - busy is therefore high for exactly N cycles, and updated HI/LO are visible in the first cycle busy==0.
- Arithmetic (all 32-bit operands):
  - mult: signed 64-bit product, hi=[63:32], lo=[31:0].
  - multu: unsigned 64-bit product.
  - div: lo=signed quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
- Divide by zero (ex_b==0, op 3 or 4):
  - Still occupies DIV_CYCLES busy cycles.
  - HI/LO unchanged at completion.
- Signed overflow: div 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- mthi/mtlo (ex_valid, busy==0): hi<=ex_a or lo<=ex_a at that edge; single cycle, busy stays 0.
- mfhi/mflo: pure reads via md_rdata; no state change.
- Ops 1-4, 7, 8 arriving while busy==1 are ignored (no state change). Correct sequencing is guaranteed by md_stall; the bench checks that the ignore occurs.
- ex_valid==0: no state change regardless of ex_mdop.
- start and md_stall depend only on the current inputs and busy; there are no registered delays.
- The scheduler never stalls EX itself. It stalls ID only.

Test Plan:
- mult, signed: ex_a=0xFFFFFFFF, ex_b=2, single-cycle start.
  - busy high 5 cycles.
  - hi/lo remain old values during busy.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- multu, same operands: after 5 cycles, hi=0x00000001, lo=0xFFFFFFFE.
- div, signed: ex_a=0xFFFFFFF9 (-7), ex_b=2.
  - busy 10 cycles.
  - lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu 7/0 with hi=0x11, lo=0x22 preloaded via mthi/mtlo:
  - busy 10 cycles.
  - hi=0x11, lo=0x22 unchanged.
- Hazard:
  - Start mult with id_is_md=1: md_stall=1 in the start cycle and all 5 busy cycles, 0 in the following cycle.
  - An mtlo 0x5 presented while busy leaves lo unchanged.
  - mflo after completion returns md_rdata=lo.
- Reset mid-operation: assert reset=0 in busy cycle 3 of a div.
  - Next cycle: busy=0, hi=lo=0.
  - No late write occurs after release.
